// File: rtl/stream_mux_pkg.sv
// Shared types for the arbitrated stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter: lowest requester at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int SELW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SELW-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SELW-1:0]   idx
);

  logic [2*NUM_CH-1:0] dreq;
  logic                found;

  assign dreq = {req, req};

  // Positions below ptr in the lower copy are masked; the upper copy wraps.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2*NUM_CH; i++) begin
      if (!found && (i >= int'(ptr)) && dreq[i]) begin
        found = 1'b1;
        idx   = SELW'(i % NUM_CH);
      end
    end
    gnt = '0;
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel arbitrated stream mux with packet locking and a registered output beat.
module stream_arb_mux
  import stream_mux_pkg::*;
#(
  parameter int        NUM_CH    = 4,
  parameter int        DATAWIDTH = 8,
  parameter arb_mode_e ARB_MODE  = ARB_RR,
  localparam int       SELW      = $clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*DATAWIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH-1:0]           in_last,
  output logic [NUM_CH-1:0]           in_ready,
  output logic [DATAWIDTH-1:0]        out_data,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [SELW-1:0]             out_sel,
  input  logic                        out_ready
);

  arb_state_e                         state;
  logic [SELW-1:0]                    lock_ch;
  logic [SELW-1:0]                    rr_ptr;
  logic [NUM_CH-1:0]                  arb_gnt;
  logic [SELW-1:0]                    arb_idx;
  logic [NUM_CH-1:0]                  lock_oh;
  logic [NUM_CH-1:0][DATAWIDTH-1:0]   ch_data;
  logic [SELW-1:0]                    sel_ch;
  logic                               can_load;
  logic                               xfer;

  assign ch_data  = in_data;
  assign can_load = !out_valid || out_ready;
  assign sel_ch   = (state == LOCKED) ? lock_ch : arb_idx;
  assign xfer     = |(in_valid & in_ready);

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req (in_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    lock_oh          = '0;
    lock_oh[lock_ch] = 1'b1;
  end

  // While locked the owner is offered ready even before it re-asserts valid.
  always_comb begin
    in_ready = '0;
    if (rst_n && can_load)
      in_ready = (state == LOCKED) ? lock_oh : arb_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lock_ch   <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[sel_ch];
      out_last  <= in_last[sel_ch];
      out_sel   <= sel_ch;
      if (in_last[sel_ch]) begin
        state <= IDLE;
        if (ARB_MODE == ARB_RR)
          rr_ptr <= (sel_ch == SELW'(NUM_CH-1)) ? '0 : sel_ch + SELW'(1);
      end else begin
        state   <= LOCKED;
        lock_ch <= sel_ch;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Random-traffic bench: one round-robin and one fixed-priority instance against a cycle reference model.
module tb_stream_arb_mux;
  import stream_mux_pkg::*;

  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int SELW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH*DW-1:0] in_data  [2];
  logic [NCH-1:0]    in_valid [2];
  logic [NCH-1:0]    in_last  [2];
  logic [NCH-1:0]    in_ready [2];
  logic [DW-1:0]     out_data [2];
  logic              out_valid[2];
  logic              out_last [2];
  logic [SELW-1:0]   out_sel  [2];
  logic              out_ready[2];

  stream_arb_mux #(.NUM_CH(NCH), .DATAWIDTH(DW), .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .out_data(out_data[0]),
    .out_valid(out_valid[0]), .out_last(out_last[0]), .out_sel(out_sel[0]),
    .out_ready(out_ready[0])
  );

  stream_arb_mux #(.NUM_CH(NCH), .DATAWIDTH(DW), .ARB_MODE(ARB_FIXED)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .out_data(out_data[1]),
    .out_valid(out_valid[1]), .out_last(out_last[1]), .out_sel(out_sel[1]),
    .out_ready(out_ready[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: packet owner (-1 = none), priority start, output register.
  int       m_owner[2];
  int       m_ptr  [2];
  bit       m_ov   [2];
  bit [7:0] m_od   [2];
  bit       m_ol   [2];
  int       m_os   [2];
  int       rem    [2][NCH];
  logic [NCH-1:0] rdy_s[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_ptr[d] = 0; m_ov[d] = 0; m_od[d] = '0; m_ol[d] = 0; m_os[d] = 0;
      for (int c = 0; c < NCH; c++) rem[d][c] = 0;
      in_valid[d] = '0; in_last[d] = '0; in_data[d] = '0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_rdy%0d", tag, d), 32'(in_ready[d]), 32'd0);
      chk($sformatf("%s_ov%0d", tag, d), 32'(out_valid[d]), 32'd0);
      chk($sformatf("%s_od%0d", tag, d), 32'(out_data[d]), 32'd0);
      chk($sformatf("%s_os%0d", tag, d), 32'(out_sel[d]), 32'd0);
      chk($sformatf("%s_ol%0d", tag, d), 32'(out_last[d]), 32'd0);
    end
  endtask

  task automatic step(input int pv, input int pr);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit can, xfer;
      int cand;
      logic [NCH-1:0] exp_rdy;
      can  = !m_ov[d] || out_ready[d];
      cand = -1;
      if (m_owner[d] >= 0) cand = m_owner[d];
      else
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (m_ptr[d] + k) % NCH;
          if (cand < 0 && in_valid[d][c]) cand = c;
        end
      exp_rdy = '0;
      if (can && cand >= 0) exp_rdy[cand] = 1'b1;
      chk($sformatf("in_ready%0d", d), 32'(in_ready[d]), 32'(exp_rdy));
      chk($sformatf("out_valid%0d", d), 32'(out_valid[d]), 32'(m_ov[d]));
      if (m_ov[d]) begin
        chk($sformatf("out_data%0d", d), 32'(out_data[d]), 32'(m_od[d]));
        chk($sformatf("out_sel%0d", d), 32'(out_sel[d]), 32'(m_os[d]));
        chk($sformatf("out_last%0d", d), 32'(out_last[d]), 32'(m_ol[d]));
      end
      rdy_s[d] = in_ready[d];
      xfer = can && cand >= 0 && in_valid[d][cand];
      if (xfer) begin
        m_ov[d] = 1;
        m_od[d] = in_data[d][cand*DW +: DW];
        m_ol[d] = in_last[d][cand];
        m_os[d] = cand;
        if (in_last[d][cand]) begin
          m_owner[d] = -1;
          if (d == 0) m_ptr[d] = (cand + 1) % NCH;
        end else begin
          m_owner[d] = cand;
        end
      end else if (out_ready[d]) begin
        m_ov[d] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) begin
        if (in_valid[d][c] && rdy_s[d][c]) in_valid[d][c] = 1'b0;
        if (!in_valid[d][c] && ($urandom % 100) < pv) begin
          if (rem[d][c] == 0) rem[d][c] = $urandom_range(1, 4);
          in_data[d][c*DW +: DW] = 8'($urandom);
          in_last[d][c] = (rem[d][c] == 1);
          rem[d][c]--;
          in_valid[d][c] = 1'b1;
        end
      end
      out_ready[d] = (($urandom % 100) < pr);
    end
  endtask

  initial begin
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    model_reset();
    #23;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) step(100, 100);
    for (int i = 0; i < 500; i++) step(60, 50);

    // Asynchronous reset mid-traffic; valids stay up so forced-low ready is visible.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 500; i++) step(30, 80);
    for (int i = 0; i < 300; i++) step(90, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
